// File: rtl/ysyx_22040127_execute.sv
// ============================================================================
//  Module   : ysyx_22040127_execute
//  Purpose  : RV64 execute stage - single-cycle ALU plus iterative mul/div.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040127_execute #(
    parameter int ID_TO_EX_WIDTH  = 242,
    parameter int EX_TO_MEM_WIDTH = 172
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_to_ex_valid,
    output logic                       ex_allowin,
    input  logic                       mem_allowin,
    output logic                       ex_to_mem_valid,
    input  logic [ID_TO_EX_WIDTH-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
    output logic                       ex_md_busy
);

    localparam logic [4:0] c_OP_ADD  = 5'd0;
    localparam logic [4:0] c_OP_SUB  = 5'd1;
    localparam logic [4:0] c_OP_SLL  = 5'd2;
    localparam logic [4:0] c_OP_SLT  = 5'd3;
    localparam logic [4:0] c_OP_SLTU = 5'd4;
    localparam logic [4:0] c_OP_XOR  = 5'd5;
    localparam logic [4:0] c_OP_SRL  = 5'd6;
    localparam logic [4:0] c_OP_SRA  = 5'd7;
    localparam logic [4:0] c_OP_OR   = 5'd8;
    localparam logic [4:0] c_OP_AND  = 5'd9;
    localparam logic [4:0] c_OP_LUI  = 5'd10;
    localparam logic [4:0] c_OP_MUL  = 5'd11;
    localparam logic [4:0] c_OP_DIV  = 5'd12;
    localparam logic [4:0] c_OP_DIVU = 5'd13;
    localparam logic [4:0] c_OP_REM  = 5'd14;
    localparam logic [4:0] c_OP_REMU = 5'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    logic                      ex_valid_q;
    logic [ID_TO_EX_WIDTH-1:0] bus_q;
    md_state_e                 state_q, state_d;
    logic [6:0]                cnt_q, cnt_d;
    logic [63:0]               a_q, a_d;
    logic [63:0]               b_q, b_d;
    logic [63:0]               acc_q, acc_d;
    logic                      negq_q, negq_d;
    logic                      negr_q, negr_d;

    logic [4:0]  w_alu_op;
    logic        w_word;
    logic [63:0] w_src1, w_src2;
    logic        w_is_md, w_is_mul, w_is_sdiv, w_is_rem, w_ready_go;

    assign w_alu_op  = bus_q[197:193];
    assign w_word    = bus_q[192];
    assign w_src1    = bus_q[191:128];
    assign w_src2    = bus_q[127:64];
    assign w_is_md   = (w_alu_op >= c_OP_MUL) && (w_alu_op <= c_OP_REMU);
    assign w_is_mul  = (w_alu_op == c_OP_MUL);
    assign w_is_sdiv = (w_alu_op == c_OP_DIV) || (w_alu_op == c_OP_REM);
    assign w_is_rem  = (w_alu_op == c_OP_REM) || (w_alu_op == c_OP_REMU);

    assign w_ready_go      = !w_is_md || (state_q == S_DONE);
    assign ex_allowin      = !ex_valid_q || (w_ready_go && mem_allowin);
    assign ex_to_mem_valid = ex_valid_q && w_ready_go;
    assign ex_md_busy      = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            if (ex_allowin) begin
                ex_valid_q <= id_to_ex_valid;
            end
            if (id_to_ex_valid && ex_allowin) begin
                bus_q <= id_to_ex_bus;
            end
        end
    end

    // ---------------- single-cycle ALU ----------------
    logic [63:0] w_op1, w_op2, w_alu_raw, w_alu_res;
    logic [5:0]  w_shamt;
    logic [31:0] w_srlw, w_sraw;

    always_comb begin
        w_op1     = w_word ? sext32(w_src1[31:0]) : w_src1;
        w_op2     = w_word ? sext32(w_src2[31:0]) : w_src2;
        w_shamt   = w_word ? {1'b0, w_src2[4:0]} : w_src2[5:0];
        w_srlw    = w_src1[31:0] >> w_src2[4:0];
        w_sraw    = $signed(w_src1[31:0]) >>> w_src2[4:0];
        w_alu_raw = '0;
        case (w_alu_op)
            c_OP_ADD:  w_alu_raw = w_op1 + w_op2;
            c_OP_SUB:  w_alu_raw = w_op1 - w_op2;
            c_OP_SLL:  w_alu_raw = w_op1 << w_shamt;
            c_OP_SLT:  w_alu_raw = {63'd0, $signed(w_op1) < $signed(w_op2)};
            c_OP_SLTU: w_alu_raw = {63'd0, w_op1 < w_op2};
            c_OP_XOR:  w_alu_raw = w_op1 ^ w_op2;
            c_OP_SRL:  w_alu_raw = w_word ? {32'd0, w_srlw} : (w_op1 >> w_shamt);
            c_OP_SRA:  w_alu_raw = w_word ? {32'd0, w_sraw} : ($signed(w_op1) >>> w_shamt);
            c_OP_OR:   w_alu_raw = w_op1 | w_op2;
            c_OP_AND:  w_alu_raw = w_op1 & w_op2;
            c_OP_LUI:  w_alu_raw = w_op2;
            default:   w_alu_raw = '0;
        endcase
        w_alu_res = w_word ? sext32(w_alu_raw[31:0]) : w_alu_raw;
    end

    // ---------------- mul/div operand preparation ----------------
    logic [63:0] w_dvd, w_dvs, w_dvd_mag, w_dvs_mag;
    logic        w_dvd_neg, w_dvs_neg, w_div_zero, w_div_ovf;
    logic [6:0]  w_iter;

    always_comb begin
        if (w_is_sdiv) begin
            w_dvd = w_word ? sext32(w_src1[31:0]) : w_src1;
            w_dvs = w_word ? sext32(w_src2[31:0]) : w_src2;
        end else begin
            w_dvd = w_word ? {32'd0, w_src1[31:0]} : w_src1;
            w_dvs = w_word ? {32'd0, w_src2[31:0]} : w_src2;
        end
        w_dvd_neg  = w_is_sdiv && w_dvd[63];
        w_dvs_neg  = w_is_sdiv && w_dvs[63];
        w_dvd_mag  = w_dvd_neg ? (64'd0 - w_dvd) : w_dvd;
        w_dvs_mag  = w_dvs_neg ? (64'd0 - w_dvs) : w_dvs;
        w_div_zero = w_word ? (w_src2[31:0] == 32'd0) : (w_src2 == 64'd0);
        w_div_ovf  = w_is_sdiv && (w_dvs == {64{1'b1}}) &&
                     (w_word ? (w_src1[31:0] == 32'h8000_0000)
                             : (w_src1 == 64'h8000_0000_0000_0000));
        w_iter     = w_word ? 7'd32 : 7'd64;
    end

    // ---------------- mul/div FSM ----------------
    // Divide shares a_q as dividend shifter / quotient collector and acc_q
    // as the partial remainder; word divides left-align the dividend.
    logic [64:0] w_trial;
    logic [63:0] w_sub;
    logic        w_ge;

    assign w_trial = {acc_q, a_q[63]};
    assign w_ge    = (w_trial >= {1'b0, b_q});
    assign w_sub   = w_trial[63:0] - b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid_q && w_is_md) begin
                    acc_d  = '0;
                    negq_d = 1'b0;
                    negr_d = 1'b0;
                    if (w_is_mul) begin
                        a_d     = w_src1;
                        b_d     = w_src2;
                        cnt_d   = w_iter;
                        state_d = S_BUSY;
                    end else if (w_div_zero) begin
                        a_d     = {64{1'b1}};
                        acc_d   = w_dvd;
                        state_d = S_DONE;
                    end else if (w_div_ovf) begin
                        a_d     = w_dvd;
                        state_d = S_DONE;
                    end else begin
                        a_d     = w_word ? {w_dvd_mag[31:0], 32'd0} : w_dvd_mag;
                        b_d     = w_dvs_mag;
                        negq_d  = w_dvd_neg ^ w_dvs_neg;
                        negr_d  = w_dvd_neg;
                        cnt_d   = w_iter;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 7'd1;
                if (w_is_mul) begin
                    acc_d = acc_q + (b_q[0] ? a_q : 64'd0);
                    a_d   = {a_q[62:0], 1'b0};
                    b_d   = {1'b0, b_q[63:1]};
                end else begin
                    a_d   = {a_q[62:0], w_ge};
                    acc_d = w_ge ? w_sub : w_trial[63:0];
                end
                if (cnt_q == 7'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ex_to_mem_valid && mem_allowin) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    // ---------------- result selection ----------------
    logic [63:0] w_quo, w_rem, w_md_raw, w_md_res, w_result;

    always_comb begin
        w_quo    = negq_q ? (64'd0 - a_q) : a_q;
        w_rem    = negr_q ? (64'd0 - acc_q) : acc_q;
        w_md_raw = w_is_mul ? acc_q : (w_is_rem ? w_rem : w_quo);
        w_md_res = w_word ? sext32(w_md_raw[31:0]) : w_md_raw;
        w_result = w_is_md ? w_md_res : w_alu_res;
    end

    assign ex_to_mem_bus = {bus_q[241:198], w_result, bus_q[63:0]};

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040127_execute.sv
// ============================================================================
//  Module   : tb_ysyx_22040127_execute
//  Purpose  : Directed scoreboard bench for the execute stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22040127_execute;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         id_to_ex_valid = 1'b0;
    logic         mem_allowin = 1'b1;
    logic [241:0] id_to_ex_bus = '0;
    logic         ex_allowin;
    logic         ex_to_mem_valid;
    logic [171:0] ex_to_mem_bus;
    logic         ex_md_busy;

    int tests = 0;
    int fails = 0;
    logic [171:0] exp_q[$];

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_MIN  = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    ysyx_22040127_execute #(
        .ID_TO_EX_WIDTH (242),
        .EX_TO_MEM_WIDTH(172)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_to_ex_valid (id_to_ex_valid),
        .ex_allowin     (ex_allowin),
        .mem_allowin    (mem_allowin),
        .ex_to_mem_valid(ex_to_mem_valid),
        .id_to_ex_bus   (id_to_ex_bus),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .ex_md_busy     (ex_md_busy)
    );

    function automatic logic [241:0] mk(input logic [4:0] op, input logic word,
                                        input logic [63:0] s1, input logic [63:0] s2);
        return {1'b0, 32'h0000_1000, 3'd0, 1'b1, 1'b0, 1'b0, 5'd1, op, word, s1, s2, 64'h0};
    endfunction

    function automatic logic [171:0] expbus(input logic [241:0] b, input logic [63:0] r);
        return {b[241:198], r, b[63:0]};
    endfunction

    task automatic check(input string tag, input logic [171:0] got, input logic [171:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handoff to the memory stage pops one expected bus.
    always @(negedge clk) begin
        if (rst && ex_to_mem_valid && mem_allowin) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL spurious_output: got %h expected no output", ex_to_mem_bus);
            end
            if (exp_q.size() != 0) begin
                check("scoreboard_bus", ex_to_mem_bus, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [241:0] b, input logic [63:0] res);
        int n = 0;
        id_to_ex_bus   = b;
        id_to_ex_valid = 1'b1;
        @(negedge clk);
        while (!ex_allowin && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 172'(ex_allowin), 172'(1));
        exp_q.push_back(expbus(b, res));
        @(posedge clk);
        #1;
        id_to_ex_valid = 1'b0;
    endtask

    // Number of cycles after the accepting edge until output is valid.
    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ex_to_mem_valid && k < 300);
    endtask

    task automatic run(input string tag, input logic [241:0] b,
                       input logic [63:0] res, input int lat);
        int k;
        send(b, res);
        wait_valid(k);
        check({tag, "_latency"}, 172'(k), 172'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic [241:0] b;

        #12;
        check("rst_allowin", 172'(ex_allowin), 172'(1));
        check("rst_valid",   172'(ex_to_mem_valid), 172'(0));
        check("rst_bus",     ex_to_mem_bus, 172'(0));
        check("rst_busy",    172'(ex_md_busy), 172'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        run("add64",  mk(5'd0, 1'b0, c_ONES, 64'd1), 64'd0, 1);
        run("addw",   mk(5'd0, 1'b1, 64'h7FFF_FFFF, 64'd1), 64'hFFFF_FFFF_8000_0000, 1);
        run("sub",    mk(5'd1, 1'b0, 64'd5, 64'd7), 64'hFFFF_FFFF_FFFF_FFFE, 1);
        run("sll6",   mk(5'd2, 1'b0, 64'd1, 64'h41), 64'd2, 1);
        run("slt",    mk(5'd3, 1'b0, c_ONES, 64'd1), 64'd1, 1);
        run("sltu",   mk(5'd4, 1'b0, c_ONES, 64'd1), 64'd0, 1);
        run("sraw",   mk(5'd7, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4), 64'hFFFF_FFFF_F800_0000, 1);
        run("srlw",   mk(5'd6, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4), 64'h0000_0000_0800_0000, 1);
        run("lui",    mk(5'd10, 1'b0, 64'd9, 64'h1234_5000), 64'h1234_5000, 1);
        run("op20",   mk(5'd20, 1'b0, 64'd5, 64'd5), 64'd0, 1);

        // mul followed by an add that must wait for the handoff
        send(mk(5'd11, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        b = mk(5'd0, 1'b0, 64'd40, 64'd2);
        id_to_ex_bus   = b;
        id_to_ex_valid = 1'b1;
        wait_valid(k);
        check("mul_latency", 172'(k), 172'(66));
        check("mul_busy_at_done", 172'(ex_md_busy), 172'(1));
        check("mul_allowin_at_done", 172'(ex_allowin), 172'(1));
        exp_q.push_back(expbus(b, 64'd42));
        @(posedge clk);
        #1;
        id_to_ex_valid = 1'b0;
        wait_valid(k);
        check("add_after_mul_latency", 172'(k), 172'(1));
        @(posedge clk);
        #1;

        run("div_by0",  mk(5'd12, 1'b0, 64'd100, 64'd0), c_ONES, 2);
        run("rem_by0",  mk(5'd14, 1'b0, 64'd100, 64'd0), 64'd100, 2);
        run("div_ovf",  mk(5'd12, 1'b0, c_MIN, c_ONES), c_MIN, 2);
        run("rem_ovf",  mk(5'd14, 1'b0, c_MIN, c_ONES), 64'd0, 2);
        run("divw_neg", mk(5'd12, 1'b1, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run("remw_neg", mk(5'd14, 1'b1, 64'hFFFF_FFF9, 64'd2), c_ONES, 34);
        run("remu64",   mk(5'd15, 1'b0, 64'd100, 64'd7), 64'd2, 66);
        run("mulw",     mk(5'd11, 1'b1, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE, 34);

        // divu word with the memory stage stalled at DONE
        mem_allowin = 1'b0;
        b = mk(5'd13, 1'b1, 64'hFFFF_FFFF, 64'd2);
        send(b, 64'h0000_0000_7FFF_FFFF);
        wait_valid(k);
        check("divuw_latency", 172'(k), 172'(34));
        for (int i = 0; i < 5; i++) begin
            check("hold_valid",   172'(ex_to_mem_valid), 172'(1));
            check("hold_allowin", 172'(ex_allowin), 172'(0));
            check("hold_bus",     ex_to_mem_bus, expbus(b, 64'h0000_0000_7FFF_FFFF));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        mem_allowin = 1'b1;
        @(posedge clk);
        #1;

        // pass-through fields
        b = {1'b1, 32'h8000_0010, 3'd3, 1'b1, 1'b0, 1'b1, 5'd9,
             5'd0, 1'b0, 64'd2, 64'd3, 64'hDEAD_BEEF_CAFE_F00D};
        send(b, 64'd5);
        wait_valid(k);
        check("pt_latency", 172'(k), 172'(1));
        check("pt_memread", 172'(ex_to_mem_bus[133]), 172'(1));
        check("pt_memop",   172'(ex_to_mem_bus[138:136]), 172'(3));
        check("pt_rd",      172'(ex_to_mem_bus[132:128]), 172'(9));
        check("pt_pc",      172'(ex_to_mem_bus[170:139]), 172'(32'h8000_0010));
        check("pt_jalr",    172'(ex_to_mem_bus[171]), 172'(1));
        @(posedge clk);
        #1;

        // asynchronous reset while the multiplier counter is at 20
        send(mk(5'd11, 1'b0, 64'd3, 64'd5), 64'd15);
        repeat (45) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_valid",   172'(ex_to_mem_valid), 172'(0));
        check("midrst_busy",    172'(ex_md_busy), 172'(0));
        check("midrst_allowin", 172'(ex_allowin), 172'(1));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run("divuw_after_rst", mk(5'd13, 1'b1, 64'd100, 64'd7), 64'd14, 34);
        run("xor_after_rst",   mk(5'd5, 1'b0, 64'hF0F0, 64'h0FF0), 64'hFF00, 1);

        check("queue_drained", 172'(exp_q.size()), 172'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22040127_execute.md
Name: ysyx_22040127_execute

Overview:
- Execute stage between decode and memory in the 5-stage RV64 pipeline.
- Registers the decode-to-execute bus under the valid/allowin handshake and computes single-cycle ALU results.
- Runs an iterative multiply/divide unit, holding the stage until the result is ready.
- Drives the 172-bit execute-to-memory bus consumed by the memory stage.

Parameters:
- ID_TO_EX_WIDTH, 242, decode-to-execute bus width.
- EX_TO_MEM_WIDTH, 172, execute-to-memory bus width (fixed by the memory stage).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_to_ex_valid  input  1  upstream payload valid.
- ex_allowin  output  1  stage can accept a payload this cycle.
- mem_allowin  input  1  memory stage can accept.
- ex_to_mem_valid  output  1  payload valid to the memory stage.
- id_to_ex_bus  input  242  decode payload (layout below).
- ex_to_mem_bus  output  172  execute payload (layout below).
- ex_md_busy  output  1  mul/div FSM is not IDLE (perf/debug).

Behaviour:
- **id_to_ex_bus layout:**
  - jalr[241], pc[240:209], memop[208:206], reg_wen[205], memwrite[204], memread[203], rd[202:198]
  - alu_op[197:193], word[192], src1[191:128], src2[127:64], wdata[63:0]
- **ex_to_mem_bus layout:**
  - jalr[171], pc[170:139], memop[138:136], reg_wen[135], memwrite[134], memread[133], rd[132:128]
  - result[127:64], wdata[63:0]
  - All fields except result are passed through unchanged from the registered input bus.
- **Handshake:**
  - ex_allowin = !ex_valid || (ex_ready_go && mem_allowin).
  - ex_to_mem_valid = ex_valid && ex_ready_go.
  - When ex_allowin is 1: ex_valid <= id_to_ex_valid.
  - When id_to_ex_valid && ex_allowin: the bus register loads id_to_ex_bus.
- **Reset (rst=0, async):**
  - ex_valid=0, bus register=0, FSM=IDLE, counter=0.
  - Resulting outputs: ex_allowin=1, ex_to_mem_valid=0, ex_to_mem_bus=0, ex_md_busy=0.
  - Reset mid-operation abandons the mul/div with no output.
- **alu_op encoding:**
  - 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 pass src2 (lui).
  - 11 mul, 12 div, 13 divu, 14 rem, 15 remu.
  - 16-31: result 0.
- **Single-cycle ops (0-10):** ex_ready_go=1, result combinational.
  - Shift amount is src2[5:0]; when word=1 it is src2[4:0].
  - word=1: operate on src1[31:0]/src2[31:0], result sign-extended from bit 31.
  - srl/sra with word=1 shift the 32-bit value.
  - slt/sltu return 0 or 1 in bit 0.
- **Mul/div FSM (ops 11-15), states IDLE, BUSY, DONE:**
  - IDLE: when ex_valid and op is mul/div, latch operands, set counter=N (64; 32 if word=1), go BUSY.
    - Exception: for divisor==0, or signed overflow (most-negative / -1), go straight to DONE.
  - BUSY: one iteration per cycle.
    - mul: shift-add, low 64 bits kept.
    - div: restoring on magnitudes, sign-corrected at DONE.
    - Counter decrements; on counter reaching 0, go DONE.
  - DONE: ex_ready_go=1. When ex_to_mem_valid && mem_allowin, go IDLE.
  - ex_ready_go=0 in IDLE and BUSY for mul/div ops.
  - Latency in stage: N+2 cycles (66 for 64-bit, 34 for word); 2 cycles for the zero-divisor/overflow cases.
  - DONE with mem_allowin=0: hold the result and stay DONE.
- **Special results:**
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Overflow: quotient = dividend, remainder = 0.
  - word=1 results are sign-extended from bit 31, including divu/remu.
- **Back-to-back ops:** a new mul/div accepted in the same cycle as the DONE handoff starts in IDLE on the next cycle.

Test Plan:
- Reset asserted mid-BUSY (counter=20) -> ex_to_mem_valid=0, ex_md_busy=0, ex_allowin=1 immediately (async); next accepted op behaves normally.
- add, src1=0xFFFFFFFF_FFFFFFFF, src2=1, word=0 -> result 0 in the cycle after acceptance. Same with word=1, src1=0x7FFFFFFF -> result 0xFFFFFFFF_80000000.
- mul 7*(-3) 64-bit -> ex_to_mem_valid rises exactly 66 cycles after acceptance with result 0xFFFFFFFF_FFFFFFEB. A following add waits until the handoff.
- div 100/0 -> result 0xFFFFFFFF_FFFFFFFF after 2 cycles. rem 100/0 -> 100. div 0x80000000_00000000/-1 -> 0x80000000_00000000. rem of the same operands -> 0.
- divu word=1, 0xFFFFFFFF/2 -> 0x00000000_7FFFFFFF after 34 cycles. With mem_allowin=0 for 5 cycles at DONE: result and valid held, ex_allowin=0, bus unchanged.
- Pass-through: memread=1, memop=3, rd=9, pc=0x80000010, jalr=1 -> identical values at bits 133, 138:136, 132:128, 170:139, 171 of ex_to_mem_bus.
